// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, single-outstanding imem handshake,
// one-entry response buffer and the IF/ID pipeline register.
module fetch_stage #(
  parameter int unsigned      XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pc_write,
  input  logic            ifid_write,
  input  logic            flush,
  input  logic [XLEN-1:0] branch_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_valid,
  input  logic [31:0]     imem_rdata,
  output logic [XLEN-1:0] ifid_pc,
  output logic [31:0]     ifid_instr,
  output logic            ifid_valid
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetchState_e;

  fetchState_e     state_q;
  logic [XLEN-1:0] pc_q;
  logic [31:0]     instrBuf_q;
  logic [XLEN-1:0] ifidPc_q;
  logic [31:0]     ifidInstr_q;
  logic            ifidValid_q;

  logic            advance;
  logic [XLEN-1:0] redirectPc;
  logic [XLEN-1:0] pcPlus4;

  // A disagreement between the two hazard enables is resolved as a stall.
  assign advance    = pc_write & ifid_write;
  assign redirectPc = branch_target & ~XLEN'(3);
  assign pcPlus4    = pc_q + XLEN'(4);

  assign imem_req   = rst_n & (state_q == FETCH);
  assign imem_addr  = pc_q;
  assign ifid_pc    = ifidPc_q;
  assign ifid_instr = ifidInstr_q;
  assign ifid_valid = ifidValid_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      instrBuf_q  <= '0;
      ifidPc_q    <= '0;
      ifidInstr_q <= NOP_INSTR;
      ifidValid_q <= 1'b0;
    end else begin
      unique case (state_q)
        FETCH: begin
          if (flush) begin
            pc_q        <= redirectPc;
            ifidPc_q    <= '0;
            ifidInstr_q <= NOP_INSTR;
            ifidValid_q <= 1'b0;
            // A flush without the response leaves a stale request in flight.
            state_q     <= imem_valid ? FETCH : DRAIN;
          end else if (imem_valid && advance) begin
            ifidPc_q    <= pc_q;
            ifidInstr_q <= imem_rdata;
            ifidValid_q <= 1'b1;
            pc_q        <= pcPlus4;
          end else if (imem_valid) begin
            instrBuf_q  <= imem_rdata;
            state_q     <= HOLD;
          end else if (ifid_write) begin
            ifidPc_q    <= pc_q;
            ifidInstr_q <= NOP_INSTR;
            ifidValid_q <= 1'b0;
          end
        end

        HOLD: begin
          if (flush) begin
            pc_q        <= redirectPc;
            ifidPc_q    <= '0;
            ifidInstr_q <= NOP_INSTR;
            ifidValid_q <= 1'b0;
            state_q     <= FETCH;
          end else if (advance) begin
            ifidPc_q    <= pc_q;
            ifidInstr_q <= instrBuf_q;
            ifidValid_q <= 1'b1;
            pc_q        <= pcPlus4;
            state_q     <= FETCH;
          end
        end

        DRAIN: begin
          if (imem_valid) begin
            state_q <= FETCH;
          end
          if (flush) begin
            pc_q        <= redirectPc;
            ifidPc_q    <= '0;
            ifidInstr_q <= NOP_INSTR;
            ifidValid_q <= 1'b0;
          end else if (ifid_write) begin
            ifidPc_q    <= pc_q;
            ifidInstr_q <= NOP_INSTR;
            ifidValid_q <= 1'b0;
          end
        end

        default: begin
          state_q <= FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a small latency-programmable memory model.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pc_write = 1'b0;
  logic        ifid_write = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] branch_target = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_instr;
  logic        ifid_valid;

  int checkCount = 0;
  int errorCount = 0;

  int          memLatency = 1;
  int          cycleNo = 0;
  int          reqCycle = 0;
  logic [31:0] reqAddr = '0;
  logic        pending = 1'b0;
  logic        prevReq = 1'b0;
  logic        prevValid = 1'b0;
  logic        newReq;

  fetch_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pc_write     (pc_write),
    .ifid_write   (ifid_write),
    .flush        (flush),
    .branch_target(branch_target),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_valid   (imem_valid),
    .imem_rdata   (imem_rdata),
    .ifid_pc      (ifid_pc),
    .ifid_instr   (ifid_instr),
    .ifid_valid   (ifid_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] addr);
    if (addr == 32'h4) return 32'h00A0_0093;
    return {16'hC0DE, addr[15:0]};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, actual, expected, cycleNo);
    end
  endtask

  // One clock cycle: drive controls at the falling edge, then let the memory
  // model respond to whatever request the DUT is presenting this cycle.
  task automatic applyStimulus(input logic rstN, input logic pw, input logic iw,
                               input logic fl, input logic [31:0] tgt);
    @(negedge clk);
    rst_n         = rstN;
    pc_write      = pw;
    ifid_write    = iw;
    flush         = fl;
    branch_target = tgt;
    imem_valid    = 1'b0;
    imem_rdata    = '0;
    #1;
    if (!rstN) begin
      pending   = 1'b0;
      prevReq   = 1'b0;
      prevValid = 1'b0;
    end else begin
      if (pending && cycleNo >= reqCycle + memLatency) begin
        imem_valid = 1'b1;
        imem_rdata = memWord(reqAddr);
        pending    = 1'b0;
      end
      newReq = imem_req && (!prevReq || prevValid);
      if (newReq) begin
        checkOutput("oneOutstanding", {31'b0, pending}, 32'h0);
        pending  = 1'b1;
        reqCycle = cycleNo;
        reqAddr  = imem_addr;
      end
      prevReq   = imem_req;
      prevValid = imem_valid;
    end
    #1;
    cycleNo++;
  endtask

  task automatic startTest(input int latency);
    memLatency = latency;
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("reqInReset", {31'b0, imem_req}, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    cycleNo = 0;
  endtask

  initial begin
    // Straight-line fetch with a 1-cycle memory.
    startTest(1);
    for (int c = 0; c <= 6; c++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      if (c == 0) begin
        checkOutput("rstIfidPc", ifid_pc, 32'h0);
        checkOutput("rstIfidInstr", ifid_instr, NOP);
        checkOutput("rstIfidValid", {31'b0, ifid_valid}, 32'h0);
        checkOutput("rstReq", {31'b0, imem_req}, 32'h1);
      end
      if (c % 2 == 0) checkOutput("seqAddr", imem_addr, 32'(c / 2 * 4));
      checkOutput("seqValid", {31'b0, ifid_valid}, {31'b0, (c >= 2 && c % 2 == 0)});
      if (c >= 2 && c % 2 == 0) begin
        checkOutput("seqIfidPc", ifid_pc, 32'((c / 2 - 1) * 4));
        checkOutput("seqIfidInstr", ifid_instr, memWord(32'((c / 2 - 1) * 4)));
      end
    end

    // Response arrives under a 2-cycle stall; buffered, then delivered.
    startTest(1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("stallRespValid", {31'b0, imem_valid}, 32'h1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("holdReq", {31'b0, imem_req}, 32'h0);
    checkOutput("holdIfidPc", ifid_pc, 32'h4);
    checkOutput("holdIfidValid", {31'b0, ifid_valid}, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("holdAddr", imem_addr, 32'h4);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("unholdIfidPc", ifid_pc, 32'h4);
    checkOutput("unholdIfidInstr", ifid_instr, 32'h00A0_0093);
    checkOutput("unholdIfidValid", {31'b0, ifid_valid}, 32'h1);
    checkOutput("unholdReq", {31'b0, imem_req}, 32'h1);
    checkOutput("unholdAddr", imem_addr, 32'h8);

    // Enable mismatch (pc_write=1, ifid_write=0) behaves as a stall.
    startTest(1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("mismatchReq", {31'b0, imem_req}, 32'h0);
    checkOutput("mismatchAddr", imem_addr, 32'h4);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("mismatchIfidInstr", ifid_instr, 32'h00A0_0093);
    checkOutput("mismatchAddrNext", imem_addr, 32'h8);

    // 3-cycle memory, flush one cycle after the request: drain the stale reply.
    startTest(3);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'h200);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("drainReq0", {31'b0, imem_req}, 32'h0);
    checkOutput("drainAddr", imem_addr, 32'h200);
    checkOutput("drainValid0", {31'b0, ifid_valid}, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("drainStaleResp", {31'b0, imem_valid}, 32'h1);
    checkOutput("drainReq1", {31'b0, imem_req}, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("redirReq", {31'b0, imem_req}, 32'h1);
    checkOutput("redirAddr", imem_addr, 32'h200);
    checkOutput("staleNotLoaded", ifid_instr, NOP);
    checkOutput("drainValid1", {31'b0, ifid_valid}, 32'h0);
    for (int c = 5; c <= 8; c++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      if (c < 8) checkOutput("redirWaitValid", {31'b0, ifid_valid}, 32'h0);
    end
    checkOutput("redirIfidPc", ifid_pc, 32'h200);
    checkOutput("redirIfidInstr", ifid_instr, 32'hC0DE_0200);
    checkOutput("redirIfidValid", {31'b0, ifid_valid}, 32'h1);

    // Flush together with the response while ifid_write=0; misaligned target.
    startTest(1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'h103);
    checkOutput("preFlushValid", {31'b0, ifid_valid}, 32'h1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("flushReq", {31'b0, imem_req}, 32'h1);
    checkOutput("flushAddr", imem_addr, 32'h100);
    checkOutput("flushIfidValid", {31'b0, ifid_valid}, 32'h0);
    checkOutput("flushIfidInstr", ifid_instr, NOP);
    checkOutput("flushIfidPc", ifid_pc, 32'h0);

    // Reset while holding a buffered instruction.
    startTest(1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("holdRstReq", {31'b0, imem_req}, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("postRstAddr", imem_addr, 32'h0);
    checkOutput("postRstReq", {31'b0, imem_req}, 32'h1);
    checkOutput("postRstValid", {31'b0, ifid_valid}, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("postRstIfidInstr", ifid_instr, 32'hC0DE_0000);
    checkOutput("postRstIfidPc", ifid_pc, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
